reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised general-purpose register file for the pipelined core; decode stage reads, write-back writes.
//  Two combinational read ports (src/dst) and two write ports (low/high, for 32-bit MUL results split over 2 regs).
//  Adds a sequential clear engine that zeroes all registers one per cycle on request, with busy/done status.
//  Optional write-to-read bypass removes the write-back -> decode hazard.
// PARAMETERS
//  DATA_W    16  width of each register in bits
//  ADDR_W    3   register address width; NUM_REGS = 2**ADDR_W (default 8: R0..R7)
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  reset         in   1       synchronous, active-high; sampled on rising edge of clk
//  rd_addr_src   in   ADDR_W  Rsrc read select
//  rd_addr_dst   in   ADDR_W  Rdst read select
//  rd_data_src   out  DATA_W  Rsrc read data (combinational)
//  rd_data_dst   out  DATA_W  Rdst read data (combinational)
//  wr_en_low     in   1       write enable, low port (normal write / MUL low half)
//  wr_addr_low   in   ADDR_W  low-port destination register
//  wr_data_low   in   DATA_W  low-port write data
//  wr_en_high    in   1       write enable, high port (MUL high half)
//  wr_addr_high  in   ADDR_W  high-port destination register
//  wr_data_high  in   DATA_W  high-port write data
//  clear_req     in   1       single-cycle request to start a scrub of all registers
//  clear_busy    out  1       high while scrub in progress
//  clear_done    out  1       one-cycle pulse when scrub completes
// BEHAVIOUR
//  Reset: every register = 0; FSM = IDLE; scrub counter = 0; clear_busy = 0; clear_done = 0.
//  Writes: registered, visible in storage the cycle after the enabling edge.
//  - Same address on both ports, both enabled: low port wins; high-port data discarded.
//  - Different addresses: both written in the same edge.
//  Reads: pure mux on stored array (no bypass unless macro below); any address legal, no X.
//  FSM states: IDLE, SCRUB.
//  - IDLE: clear_req=1 -> SCRUB, cnt <= 0. Normal writes accepted.
//  - SCRUB: each edge reg[cnt] <= 0, cnt <= cnt+1; at cnt == NUM_REGS-1 -> IDLE, clear_done <= 1.
//  - clear_busy = (state == SCRUB); asserted the cycle after clear_req, held exactly NUM_REGS cycles.
//  - clear_done high exactly one cycle: the first cycle back in IDLE.
//  - Writes (either port) during SCRUB are dropped, whatever their address; reads return stored values.
//  - clear_req during SCRUB is ignored (no restart, no queueing).
//  - clear_req in the same cycle as a write in IDLE: the write commits; the scrub then zeroes it.
//  - reset mid-scrub: immediate return to IDLE, all registers 0, no clear_done pulse.
//  - cnt is ADDR_W bits; terminal-count compare, no wrap beyond NUM_REGS-1.
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined: a read whose address matches an enabled, accepted write this cycle returns that
//   write data combinationally. Low port takes precedence over high on a double match. No bypass during SCRUB
//   (writes dropped), so reads then return stored values.
//  REG_FILE_BYPASS_EN undefined: reads always return stored values; the new value appears one cycle after the write.
// TESTING
//  1 reset=1 one edge, then read all 8 addrs on both ports -> all 0, clear_busy=0, clear_done=0.
//  2 wr_en_low=1 addr 3 data 16'hA5A5 and wr_en_high=1 addr 3 data 16'h1234, same edge -> R3 = 16'hA5A5.
//  3 MUL write: low addr 1 data 16'h0002, high addr 2 data 16'hFFFF -> next cycle R1=16'h0002, R2=16'hFFFF.
//  4 Fill R0..R7 with 16'h00FF, pulse clear_req -> busy high 8 cycles, done pulse 1 cycle, all regs 0;
//    write addr 5 data 16'h7777 mid-scrub -> R5 = 0 after done; second clear_req mid-scrub -> no restart.
//  5 Reset asserted on 4th scrub cycle -> next cycle busy=0, done never pulses, all regs 0.
//  6 Write R4=16'hBEEF, read src=4 same cycle -> 16'hBEEF with REG_FILE_BYPASS_EN; old value without it.

Source files
------------

// File: rtl/reg_file_param.sv
// General-purpose register file: two combinational read ports, low/high write ports, one-register-per-cycle scrub engine.
// Optional macro REG_FILE_BYPASS_EN forwards accepted same-cycle write data to the read ports.
module reg_file_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_src,
  input  logic [ADDR_W-1:0] rd_addr_dst,
  output logic [DATA_W-1:0] rd_data_src,
  output logic [DATA_W-1:0] rd_data_dst,
  input  logic              wr_en_low,
  input  logic [ADDR_W-1:0] wr_addr_low,
  input  logic [DATA_W-1:0] wr_data_low,
  input  logic              wr_en_high,
  input  logic [ADDR_W-1:0] wr_addr_high,
  input  logic [DATA_W-1:0] wr_data_high,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              wr_acc_low;
  logic              wr_acc_high;
  logic [DATA_W-1:0] stored_src;
  logic [DATA_W-1:0] stored_dst;

  // Writes are only accepted while the scrub engine is idle.
  assign wr_acc_low  = wr_en_low  && (state_q == IDLE);
  assign wr_acc_high = wr_en_high && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = SCRUB;
          cnt_d   = '0;
        end
      end
      SCRUB: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    // High port first so the low port overrides it on an address collision.
    if (wr_acc_high) begin
      regs_d[wr_addr_high] = wr_data_high;
    end
    if (wr_acc_low) begin
      regs_d[wr_addr_low] = wr_data_low;
    end
    if (state_q == SCRUB) begin
      regs_d[cnt_q] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign stored_src = regs_q[rd_addr_src];
  assign stored_dst = regs_q[rd_addr_dst];

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    rd_data_src = stored_src;
    if (wr_acc_low && (wr_addr_low == rd_addr_src)) begin
      rd_data_src = wr_data_low;
    end else if (wr_acc_high && (wr_addr_high == rd_addr_src)) begin
      rd_data_src = wr_data_high;
    end
  end

  always_comb begin
    rd_data_dst = stored_dst;
    if (wr_acc_low && (wr_addr_low == rd_addr_dst)) begin
      rd_data_dst = wr_data_low;
    end else if (wr_acc_high && (wr_addr_high == rd_addr_dst)) begin
      rd_data_dst = wr_data_high;
    end
  end
`else
  assign rd_data_src = stored_src;
  assign rd_data_dst = stored_dst;
`endif

  assign clear_busy = (state_q == SCRUB);
  assign clear_done = done_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: stimulus pushes expected read/status values, a negedge monitor pops and compares.
module tb_reg_file_param;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr_src, rd_addr_dst;
  logic [DW-1:0] rd_data_src, rd_data_dst;
  logic          wr_en_low, wr_en_high;
  logic [AW-1:0] wr_addr_low, wr_addr_high;
  logic [DW-1:0] wr_data_low, wr_data_high;
  logic          clear_req;
  logic          clear_busy, clear_done;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_addr_src  (rd_addr_src),
    .rd_addr_dst  (rd_addr_dst),
    .rd_data_src  (rd_data_src),
    .rd_data_dst  (rd_data_dst),
    .wr_en_low    (wr_en_low),
    .wr_addr_low  (wr_addr_low),
    .wr_data_low  (wr_data_low),
    .wr_en_high   (wr_en_high),
    .wr_addr_high (wr_addr_high),
    .wr_data_high (wr_data_high),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] src;
    logic [DW-1:0] dst;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  logic probe = 1'b0;
  int   checks = 0;
  int   failures = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string name, input string field, input logic [DW-1:0] act,
                     input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, expv);
    end
  endtask

  // Monitor: one expected entry per probed cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard: probe with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, "src",  rd_data_src, e.src);
        chk(e.name, "dst",  rd_data_dst, e.dst);
        chk(e.name, "busy", {15'd0, clear_busy}, {15'd0, e.busy});
        chk(e.name, "done", {15'd0, clear_done}, {15'd0, e.done});
      end
    end
  end

  task automatic expect_rd(input string name, input int a_src, input int a_dst,
                           input logic [DW-1:0] e_src, input logic [DW-1:0] e_dst,
                           input logic e_busy, input logic e_done);
    exp_t e;
    rd_addr_src = AW'(a_src);
    rd_addr_dst = AW'(a_dst);
    e.name = name; e.src = e_src; e.dst = e_dst; e.busy = e_busy; e.done = e_done;
    exp_q.push_back(e);
    probe = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic wr_low(input int a, input logic [DW-1:0] d);
    wr_en_low = 1'b1; wr_addr_low = AW'(a); wr_data_low = d;
  endtask

  task automatic wr_high(input int a, input logic [DW-1:0] d);
    wr_en_high = 1'b1; wr_addr_high = AW'(a); wr_data_high = d;
  endtask

  task automatic wr_off();
    wr_en_low = 1'b0; wr_en_high = 1'b0;
    wr_addr_low = '0; wr_addr_high = '0; wr_data_low = '0; wr_data_high = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_req = 1'b0;
    rd_addr_src = '0; rd_addr_dst = '0;
    wr_off();
    tick();
    reset = 1'b0;

    // 1: reset state on every address
    for (int i = 0; i < 8; i++) begin
      expect_rd("reset_rd", i, 7 - i, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
    end

    // 2: same-address collision, low port wins
    wr_low(3, 16'hA5A5); wr_high(3, 16'h1234);
    tick();
    wr_off();
    expect_rd("collide", 3, 3, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0);
    tick();

    // 3: MUL split write
    wr_low(1, 16'h0002); wr_high(2, 16'hFFFF);
    tick();
    wr_off();
    expect_rd("mul", 1, 2, 16'h0002, 16'hFFFF, 1'b0, 1'b0);
    tick();

    // 4: fill with 00FF, then scrub
    for (int i = 0; i < 8; i += 2) begin
      wr_low(i, 16'h00FF); wr_high(i + 1, 16'h00FF);
      tick();
    end
    wr_off();
    expect_rd("fill", 0, 7, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
    tick();
    // Write in the same cycle as the request commits, then gets scrubbed.
    clear_req = 1'b1;
    wr_low(6, 16'h1111);
    expect_rd("req_cycle", 2, 3, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
    tick();
    clear_req = 1'b0;
    wr_off();
    for (int k = 0; k < 8; k++) begin
      logic [DW-1:0] es, ed;
      es = (k == 6) ? 16'h1111 : 16'h00FF;
      ed = (k == 0) ? 16'h00FF : 16'h0000;
      if (k == 2) begin
        wr_low(5, 16'h7777); wr_high(4, 16'h5555);
      end
      if (k == 4) clear_req = 1'b1;
      expect_rd("scrub", k, (k == 0) ? 7 : k - 1, es, ed, 1'b1, 1'b0);
      tick();
      wr_off();
      clear_req = 1'b0;
    end
    expect_rd("scrub_done", 5, 6, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    expect_rd("scrub_after", 7, 4, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    expect_rd("no_restart", 0, 1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();

    // 5: reset on the 4th scrub cycle
    wr_low(5, 16'h5555); wr_high(6, 16'h6666);
    tick();
    wr_off();
    clear_req = 1'b1;
    expect_rd("pre_scrub5", 5, 6, 16'h5555, 16'h6666, 1'b0, 1'b0);
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) reset = 1'b1;
      expect_rd("scrub5", 5, 6, 16'h5555, 16'h6666, 1'b1, 1'b0);
      tick();
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_rd("post_rst", 5, 6, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
    end

    // 6: same-cycle read of a write (bypass-dependent)
    wr_low(4, 16'hBEEF); wr_high(7, 16'h7777);
    expect_rd("bypass", 4, 7, BYP ? 16'hBEEF : 16'h0000, BYP ? 16'h7777 : 16'h0000, 1'b0, 1'b0);
    tick();
    wr_off();
    expect_rd("bypass_next", 4, 7, 16'hBEEF, 16'h7777, 1'b0, 1'b0);
    tick();
    wr_low(2, 16'hAAAA); wr_high(2, 16'hBBBB);
    expect_rd("bypass_dbl", 2, 2, BYP ? 16'hAAAA : 16'h0000, BYP ? 16'hAAAA : 16'h0000, 1'b0, 1'b0);
    tick();
    wr_off();
    expect_rd("dbl_next", 2, 4, 16'hAAAA, 16'hBEEF, 1'b0, 1'b0);
    tick();

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
